// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl
// Occupancy sequencer for an in-order NUM_STAGES pipeline. It tracks which
// stages hold a live instruction and drives the per-stage register load
// enables. A load-use hazard inserts a bubble, and a branch redirect flushes
// the younger stages. A halt drains the pipeline and reports completion. The
// block also keeps a saturating count of retired instructions.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   valid        fetch offers a new instruction
//   hazard       load-use hazard seen in stage STALL_STAGE+1
//   redirect     taken branch resolved in stage FLUSH_DEPTH
//   halt         level request to stop issuing and drain
//   stage_en     per-stage register load enable (combinational)
//   stage_vld    per-stage occupancy (registered), bit 0 = fetch
//   accept       instruction taken into stage 0 this cycle (combinational)
//   retire       last stage occupied
//   opr_finished high while the pipeline sits drained after a halt
//   retired_cnt  saturating retire count
//   state        IDLE=0, RUN=1, DRAIN=2, DONE=3
module pipe_stage_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  hazard,
  input  logic                  redirect,
  input  logic                  halt,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_vld,
  output logic                  accept,
  output logic                  retire,
  output logic                  opr_finished,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [NUM_STAGES-1:0] vld_shift;
  logic [NUM_STAGES-1:0] vld_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Issue decision and next occupancy
  always_comb begin
    accept    = 1'b0;
    stage_en  = '0;
    vld_nxt   = stage_vld;
    if (!reset)
      accept = valid & ~halt & ~hazard & ~redirect &
               ((state_q == IDLE) | (state_q == RUN));
    // Plain advance: every stage takes its predecessor, stage 0 takes accept.
    vld_shift = {stage_vld[NUM_STAGES-2:0], accept};
    if (!reset) begin
      if ((state_q == IDLE) || (state_q == DONE)) begin
        stage_en[0] = accept;
        vld_nxt[0]  = accept;
      end else if (redirect) begin
        // The resolving branch moves on; everything younger is killed.
        stage_en = '1;
        for (int i = 0; i < NUM_STAGES; i++)
          vld_nxt[i] = (i <= FLUSH_DEPTH) ? 1'b0 : vld_shift[i];
      end else if (hazard) begin
        // Front stages freeze, a bubble enters behind them, the rest advance.
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i <= STALL_STAGE) begin
            stage_en[i] = 1'b0;
            vld_nxt[i]  = stage_vld[i];
          end else if (i == STALL_STAGE + 1) begin
            stage_en[i] = 1'b1;
            vld_nxt[i]  = 1'b0;
          end else begin
            stage_en[i] = 1'b1;
            vld_nxt[i]  = vld_shift[i];
          end
        end
      end else begin
        stage_en = '1;
        vld_nxt  = vld_shift;
      end
    end
  end

  // Registered occupancy, FSM and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      stage_vld    <= '0;
      opr_finished <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      stage_vld <= vld_nxt;
      if (retire)
        retired_cnt <= sat_inc(retired_cnt);
      case (state_q)
        IDLE:  if (accept) state_q <= RUN;
        RUN:   if (halt) state_q <= DRAIN;
        DRAIN: if (vld_nxt == '0) begin
                 state_q      <= DONE;
                 opr_finished <= 1'b1;
               end
        DONE:  if (!halt) begin
                 state_q      <= IDLE;
                 opr_finished <= 1'b0;
               end
      endcase
    end
  end

  assign retire = stage_vld[NUM_STAGES-1];
  assign state  = state_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Testbench for pipe_stage_ctrl: a default-shaped instance (5 stages, 4-bit
// counter) and a 7-stage instance share one stimulus stream, each checked
// against its own reference model through a scoreboard queue.
module tb_pipe_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, valid = 1'b0, hazard = 1'b0, redirect = 1'b0, halt = 1'b0;

  logic [4:0] en5, vld5;
  logic       acc5, ret5, fin5;
  logic [3:0] cnt5;
  logic [1:0] st5;
  logic [6:0] en7, vld7;
  logic       acc7, ret7, fin7;
  logic [7:0] cnt7;
  logic [1:0] st7;

  pipe_stage_ctrl #(.NUM_STAGES(5), .STALL_STAGE(1), .FLUSH_DEPTH(2), .CNT_W(4)) u_dut5 (
    .clk(clk), .reset(reset), .valid(valid), .hazard(hazard), .redirect(redirect),
    .halt(halt), .stage_en(en5), .stage_vld(vld5), .accept(acc5), .retire(ret5),
    .opr_finished(fin5), .retired_cnt(cnt5), .state(st5));

  pipe_stage_ctrl #(.NUM_STAGES(7), .STALL_STAGE(2), .FLUSH_DEPTH(3), .CNT_W(8)) u_dut7 (
    .clk(clk), .reset(reset), .valid(valid), .hazard(hazard), .redirect(redirect),
    .halt(halt), .stage_en(en7), .stage_vld(vld7), .accept(acc7), .retire(ret7),
    .opr_finished(fin7), .retired_cnt(cnt7), .state(st7));

  typedef struct {
    logic [6:0] vld;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       fin;
  } exp_t;

  exp_t q5[$];
  exp_t q7[$];

  logic [1:0] m_st  [2];
  logic [6:0] m_vld [2];
  logic [7:0] m_cnt [2];

  logic       cap_acc5;
  logic [4:0] cap_en5;
  logic [6:0] cap_en7;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: behaviour written with stage masks for n stages,
  // stall index s, flush depth f and counter width cw.
  task automatic model_step(input int k, input int n, input int s, input int f, input int cw,
                            output logic acc, output logic [6:0] en, output exp_t e);
    logic [6:0] v, nv, sh, mask;
    logic [1:0] st, nst;
    logic [7:0] c, cmax;
    v    = m_vld[k];
    st   = m_st[k];
    c    = m_cnt[k];
    mask = 7'((1 << n) - 1);
    cmax = 8'((1 << cw) - 1);
    acc  = 1'b0;
    en   = '0;
    nv   = v;
    nst  = st;
    if (reset) begin
      nv  = '0;
      nst = 2'd0;
      c   = '0;
    end else begin
      acc = valid && !halt && !hazard && !redirect && (st == 2'd0 || st == 2'd1);
      sh  = (v << 1) | {6'b0, acc};
      if (st == 2'd0 || st == 2'd3) begin
        en    = {6'b0, acc};
        nv[0] = acc;
      end else if (redirect) begin
        en = mask;
        nv = sh & ~7'((1 << (f + 1)) - 1);
      end else if (hazard) begin
        en = mask & ~7'((1 << (s + 1)) - 1);
        nv = (v & 7'((1 << (s + 1)) - 1)) | (sh & ~7'((1 << (s + 2)) - 1));
      end else begin
        en = mask;
        nv = sh;
      end
      nv = nv & mask;
      if (v[n-1] && c != cmax) c = c + 8'd1;
      case (st)
        2'd0: if (acc) nst = 2'd1;
        2'd1: if (halt) nst = 2'd2;
        2'd2: if (nv == '0) nst = 2'd3;
        2'd3: if (!halt) nst = 2'd0;
      endcase
    end
    m_vld[k] = nv;
    m_st[k]  = nst;
    m_cnt[k] = c;
    e.vld = nv;
    e.st  = nst;
    e.cnt = c;
    e.fin = (nst == 2'd3);
  endtask

  task automatic step(input logic rs, input logic v, input logic z, input logic r, input logic h);
    logic       a5, a7;
    logic [6:0] e5, e7;
    exp_t       x5, x7, p;
    @(negedge clk);
    reset = rs; valid = v; hazard = z; redirect = r; halt = h;
    #1;
    model_step(0, 5, 1, 2, 4, a5, e5, x5);
    model_step(1, 7, 2, 3, 8, a7, e7, x7);
    cap_acc5 = acc5;
    cap_en5  = en5;
    cap_en7  = en7;
    chk("accept5", 32'(acc5), 32'(a5));
    chk("stage_en5", 32'(en5), 32'(e5[4:0]));
    chk("accept7", 32'(acc7), 32'(a7));
    chk("stage_en7", 32'(en7), 32'(e7));
    q5.push_back(x5);
    q7.push_back(x7);
    @(posedge clk);
    #1;
    p = q5.pop_front();
    chk("stage_vld5", 32'(vld5), 32'(p.vld[4:0]));
    chk("state5", 32'(st5), 32'(p.st));
    chk("retired_cnt5", 32'(cnt5), 32'(p.cnt[3:0]));
    chk("opr_finished5", 32'(fin5), 32'(p.fin));
    chk("retire5", 32'(ret5), 32'(p.vld[4]));
    p = q7.pop_front();
    chk("stage_vld7", 32'(vld7), 32'(p.vld));
    chk("state7", 32'(st7), 32'(p.st));
    chk("retired_cnt7", 32'(cnt7), 32'(p.cnt));
    chk("opr_finished7", 32'(fin7), 32'(p.fin));
    chk("retire7", 32'(ret7), 32'(p.vld[6]));
  endtask

  task automatic fill(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [4:0] fill_tab  [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
  logic [4:0] drain_tab [5] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};

  initial begin
    // Reset with valid high: nothing accepted, everything cleared.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_accept", 32'(cap_acc5), 32'd0);
    chk("rst_stage_en", 32'(cap_en5), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", 32'(st5), 32'd0);
    chk("rst_vld", 32'(vld5), 32'd0);
    chk("rst_cnt", 32'(cnt5), 32'd0);
    chk("rst_fin", 32'(fin5), 32'd0);

    // Fill
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 5) chk("fill_vld5", 32'(vld5), 32'(fill_tab[i]));
    end
    chk("fill_state5", 32'(st5), 32'd1);
    chk("fill_vld7", 32'(vld7), 32'h7f);

    // Single hazard on a full pipe
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("haz_accept", 32'(cap_acc5), 32'd0);
    chk("haz_en5", 32'(cap_en5), 32'b11100);
    chk("haz_en7", 32'(cap_en7), 32'b1111000);
    chk("haz_vld5", 32'(vld5), 32'b11011);
    chk("haz_vld7", 32'(vld7), 32'b1110111);

    // Held hazard: front stages stay frozen
    fill(7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("hold_front5", 32'(vld5[1:0]), 32'b11);
      chk("hold_en_front5", 32'(cap_en5[1:0]), 32'b00);
    end

    // Redirect together with hazard: redirect wins
    fill(7);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("redir_haz_accept", 32'(cap_acc5), 32'd0);
    chk("redir_haz_vld5", 32'(vld5), 32'b11000);
    chk("redir_haz_vld7", 32'(vld7), 32'b1110000);

    // Redirect alone
    fill(7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("redir_vld5", 32'(vld5), 32'b11000);
    chk("redir_vld7", 32'(vld7), 32'b1110000);

    // Halt and drain
    fill(7);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i < 5) chk("drain_vld5", 32'(vld5), 32'(drain_tab[i]));
      if (i == 0) chk("drain_state5", 32'(st5), 32'd2);
      if (i == 3) chk("drain_fin5_early", 32'(fin5), 32'd0);
      if (i == 4) begin
        chk("done_state5", 32'(st5), 32'd3);
        chk("done_fin5", 32'(fin5), 32'd1);
      end
    end
    chk("done_state7", 32'(st7), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_state5", 32'(st5), 32'd0);
    chk("idle_fin5", 32'(fin5), 32'd0);

    // Counter saturation from a clean start
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(25);
    chk("sat_cnt5", 32'(cnt5), 32'd15);
    chk("cnt7", 32'(cnt7), 32'd18);

    // Reset in the middle of a fill
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(3);
    chk("midfill_vld5", 32'(vld5), 32'b00111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_accept", 32'(cap_acc5), 32'd0);
    chk("midrst_en5", 32'(cap_en5), 32'd0);
    chk("midrst_vld5", 32'(vld5), 32'd0);
    chk("midrst_state5", 32'(st5), 32'd0);
    chk("midrst_cnt5", 32'(cnt5), 32'd0);

    // Halt together with redirect: flush and go to DRAIN
    fill(5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("halt_redir_state5", 32'(st5), 32'd2);
    chk("halt_redir_vld5", 32'(vld5), 32'b11000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
